// File: rtl/transmitter_packet_arbiter.sv
//------------------------------------------------------------------------------
// transmitter_packet_arbiter
//
// Merges the DLLP and TLP framer byte streams onto one registered byte lane
// toward the physical layer. A packet, once granted, owns the lane until its
// last byte is acked. A framer that drops its request mid-packet gets IDLE_K
// bytes and an underrun pulse, but it keeps the grant. At least one IDLE_K
// byte always separates two packets.
//
// DLLPs normally win arbitration. After DLLP_BURST_MAX back-to-back DLLP
// grants taken while a TLP was waiting, the TLP wins once so it cannot starve.
//
// Optional feature: define TX_ARB_SKP_INSERT_EN to compile periodic SKP
// insertion. Every SKP_INTERVAL cycles a pair of SKP_K bytes is sent between
// packets. It is never sent inside a packet.
//
// Ports:
//   i_clk, i_arst_n              clock, async active-low reset
//   i_dllp_req/k_en/byte/last    DLLP framer byte stream
//   o_dllp_ack                   DLLP byte consumed this cycle (combinational)
//   i_tlp_req/k_en/byte/last     TLP framer byte stream
//   o_tlp_ack                    TLP byte consumed this cycle (combinational)
//   o_phys_packet_k_en/byte      registered lane output, 1 cycle after ack
//   o_grant                      01 DLLP, 10 TLP, 00 none
//   o_busy                       arbiter is not idle
//   o_underrun                   granted framer had no byte last cycle
//------------------------------------------------------------------------------
module transmitter_packet_arbiter #(
  parameter int unsigned DLLP_BURST_MAX = 4,
  parameter int unsigned SKP_INTERVAL   = 1024,
  parameter logic [7:0]  IDLE_K         = 8'hBC,
  parameter logic [7:0]  SKP_K          = 8'h1C
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_dllp_req,
  input  logic       i_dllp_k_en,
  input  logic [7:0] i_dllp_byte,
  input  logic       i_dllp_last,
  output logic       o_dllp_ack,
  input  logic       i_tlp_req,
  input  logic       i_tlp_k_en,
  input  logic [7:0] i_tlp_byte,
  input  logic       i_tlp_last,
  output logic       o_tlp_ack,
  output logic       o_phys_packet_k_en,
  output logic [7:0] o_phys_packet_byte,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_underrun
);

  localparam logic [3:0] BURST_MAX = 4'(DLLP_BURST_MAX);

  // An out-of-range configuration elaborates this empty marker block. It
  // shows up by name in the elaborated hierarchy.
  if (DLLP_BURST_MAX == 0 || DLLP_BURST_MAX > 15 || SKP_INTERVAL < 16 ||
      SKP_INTERVAL > 65535 || SKP_K == IDLE_K) begin : g_bad_config
  end

`ifdef TX_ARB_SKP_INSERT_EN
  typedef enum logic [1:0] {S_IDLE, S_GNT_DLLP, S_GNT_TLP, S_SKP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_GNT_DLLP, S_GNT_TLP} state_e;
`endif

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       phys_k_q, phys_k_d;
  logic [7:0] phys_byte_q, phys_byte_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       underrun_q, underrun_d;
  logic       dllp_ack, tlp_ack, tlp_starved;

  // Reset release is brought into i_clk through two stages. The arbiter
  // grants nothing until the release has passed both stages.
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

`ifdef TX_ARB_SKP_INSERT_EN
  localparam logic [15:0] SKP_LAST = 16'(SKP_INTERVAL - 1);
  logic [15:0] skp_cnt_q, skp_cnt_d;
  logic        skp_pend_q, skp_pend_d;
  logic        skp_second_q, skp_second_d;
`endif

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    phys_k_d    = 1'b1;
    phys_byte_d = IDLE_K;
    underrun_d  = 1'b0;
    dllp_ack    = 1'b0;
    tlp_ack     = 1'b0;
    tlp_starved = i_tlp_req && (burst_q == BURST_MAX);
`ifdef TX_ARB_SKP_INSERT_EN
    skp_cnt_d    = skp_cnt_q;
    skp_pend_d   = skp_pend_q;
    skp_second_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (run) begin
`ifdef TX_ARB_SKP_INSERT_EN
          if (skp_pend_q) begin
            state_d = S_SKP;
          end else
`endif
          if (i_dllp_req && !tlp_starved) begin
            state_d = S_GNT_DLLP;
            // Only DLLP grants that jump ahead of a waiting TLP count
            // toward the burst limit.
            burst_d = i_tlp_req ? burst_q + 4'd1 : 4'd0;
          end else if (i_tlp_req) begin
            state_d = S_GNT_TLP;
            burst_d = 4'd0;
          end
        end
      end

      S_GNT_DLLP: begin
        if (i_dllp_req) begin
          dllp_ack    = 1'b1;
          phys_k_d    = i_dllp_k_en;
          phys_byte_d = i_dllp_byte;
          if (i_dllp_last) state_d = S_IDLE;
        end else begin
          underrun_d = 1'b1;
        end
      end

      S_GNT_TLP: begin
        if (i_tlp_req) begin
          tlp_ack     = 1'b1;
          phys_k_d    = i_tlp_k_en;
          phys_byte_d = i_tlp_byte;
          if (i_tlp_last) state_d = S_IDLE;
        end else begin
          underrun_d = 1'b1;
        end
      end

`ifdef TX_ARB_SKP_INSERT_EN
      S_SKP: begin
        phys_byte_d  = SKP_K;
        skp_second_d = !skp_second_q;
        if (skp_second_q) state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase

`ifdef TX_ARB_SKP_INSERT_EN
    // The interval counter saturates at its last value and holds the pending
    // flag there. This keeps a deferred SKP alive through a long packet.
    if (state_q == S_IDLE && state_d == S_SKP) begin
      skp_cnt_d  = 16'd0;
      skp_pend_d = 1'b0;
    end else if (run) begin
      if (skp_cnt_q == SKP_LAST) skp_pend_d = 1'b1;
      else                       skp_cnt_d  = skp_cnt_q + 16'd1;
    end
`endif

    grant_d = 2'b00;
    if (state_d == S_GNT_DLLP)     grant_d = 2'b01;
    else if (state_d == S_GNT_TLP) grant_d = 2'b10;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= S_IDLE;
      burst_q     <= 4'd0;
      phys_k_q    <= 1'b1;
      phys_byte_q <= IDLE_K;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      phys_k_q    <= phys_k_d;
      phys_byte_q <= phys_byte_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef TX_ARB_SKP_INSERT_EN
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      skp_cnt_q    <= 16'd0;
      skp_pend_q   <= 1'b0;
      skp_second_q <= 1'b0;
    end else begin
      skp_cnt_q    <= skp_cnt_d;
      skp_pend_q   <= skp_pend_d;
      skp_second_q <= skp_second_d;
    end
  end
`endif

  assign o_dllp_ack         = dllp_ack;
  assign o_tlp_ack          = tlp_ack;
  assign o_phys_packet_k_en = phys_k_q;
  assign o_phys_packet_byte = phys_byte_q;
  assign o_grant            = grant_q;
  assign o_busy             = busy_q;
  assign o_underrun         = underrun_q;

endmodule

// File: tb/tb_transmitter_packet_arbiter.sv
//------------------------------------------------------------------------------
// tb_transmitter_packet_arbiter
// The framers are modelled as byte queues. A lane-ownership model predicts
// grant, ack, lane byte and underrun every cycle from the arbitration rules.
// Directed scenarios run first, then a randomized phase, then the
// reset-abort scenario.
//------------------------------------------------------------------------------
module tb_transmitter_packet_arbiter;
  localparam int         BURST   = 4;
  localparam int         SKP_IVL = 16;
  localparam logic [7:0] IDLE_K  = 8'hBC;
  localparam logic [7:0] SKP_K   = 8'h1C;
`ifdef TX_ARB_SKP_INSERT_EN
  localparam bit SKP_EN = 1'b1;
`else
  localparam bit SKP_EN = 1'b0;
`endif
  localparam int O_NONE = 0, O_D = 1, O_T = 2, O_SKP = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic dreq = 1'b0, dk = 1'b0, dlast = 1'b0, treq = 1'b0, tk = 1'b0, tlast = 1'b0;
  logic [7:0] db = 8'h0, tb = 8'h0;
  logic dack, tack, phys_k, busy, under;
  logic [7:0] phys_b;
  logic [1:0] grant;

  always #5 clk = ~clk;

  transmitter_packet_arbiter #(
    .DLLP_BURST_MAX(BURST), .SKP_INTERVAL(SKP_IVL), .IDLE_K(IDLE_K), .SKP_K(SKP_K)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_dllp_req(dreq), .i_dllp_k_en(dk), .i_dllp_byte(db), .i_dllp_last(dlast),
    .o_dllp_ack(dack),
    .i_tlp_req(treq), .i_tlp_k_en(tk), .i_tlp_byte(tb), .i_tlp_last(tlast),
    .o_tlp_ack(tack),
    .o_phys_packet_k_en(phys_k), .o_phys_packet_byte(phys_b),
    .o_grant(grant), .o_busy(busy), .o_underrun(under)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Framer byte queues. Each entry is {last, k_en, byte}.
  logic [9:0] dq[$], tq[$];
  int stall_d = 0, stall_t = 0;
  bit rnd_mode = 0, arm_t_stall = 0;
  int d_acks = 0, t_acks = 0, u_cnt = 0, skp_seen = 0;
  int gq[$];
  int exp31[10];

  // Lane-ownership model state.
  int owner = O_NONE, streak = 0, elapsed = 0, skp_left = 0, sync_cnt = 0;
  int exp_phys = {24'd0, 1'b1, IDLE_K};
  int exp_under = 0, prev_grant = 0;
  bit d_ackd = 0, t_ackd = 0;

  task automatic push_pkt(int s, int len, bit first_k);
    for (int i = 0; i < len; i++) begin
      logic [9:0] w;
      w[7:0] = 8'($urandom);
      w[8]   = ($urandom % 4 == 0);
      if (w[8] && w[7:0] == SKP_K) w[7:0] = 8'h3C;
      if (i == 0 && first_k) w[8:0] = {1'b1, IDLE_K};
      w[9] = (i == len - 1);
      if (s == 0) dq.push_back(w); else tq.push_back(w);
    end
  endtask

  task automatic drive();
    if (dq.size() > 0 && stall_d == 0) begin dreq = 1'b1; {dlast, dk, db} = dq[0]; end
    else begin dreq = 1'b0; {dlast, dk, db} = 10'($urandom); end
    if (tq.size() > 0 && stall_t == 0) begin treq = 1'b1; {tlast, tk, tb} = tq[0]; end
    else begin treq = 1'b0; {tlast, tk, tb} = 10'($urandom); end
  endtask

  // Called just after a rising edge: consume acked bytes, then present the
  // next inputs.
  task automatic advance();
    if (rst_n && sync_cnt < 2) sync_cnt++;
    if (d_ackd) begin void'(dq.pop_front()); d_acks++; end
    if (t_ackd) begin void'(tq.pop_front()); t_acks++; end
    d_ackd = 0; t_ackd = 0;
    if (arm_t_stall && t_acks == 7) begin stall_t = 3; arm_t_stall = 0; end
    if (rnd_mode) begin
      if (dq.size() == 0 && $urandom % 6 == 0) push_pkt(0, 1 + int'($urandom % 8), 1'b1);
      if (tq.size() == 0 && $urandom % 6 == 0) push_pkt(1, 1 + int'($urandom % 12), 1'b0);
      if (stall_d == 0 && $urandom % 10 == 0) stall_d = 1 + int'($urandom % 3);
      if (stall_t == 0 && $urandom % 10 == 0) stall_t = 1 + int'($urandom % 3);
    end
    drive();
    if (stall_d > 0) stall_d--;
    if (stall_t > 0) stall_t--;
  endtask

  // Called on the falling edge: compare outputs against the model, then work
  // out what the lane owes the next cycle.
  task automatic check_cycle();
    bit ed, et;
    if (!rst_n) begin
      chk("rst_out", int'({phys_k, phys_b, grant, busy, under, dack, tack}),
          int'({1'b1, IDLE_K, 6'b0}));
      owner = O_NONE; streak = 0; elapsed = 0; skp_left = 0; sync_cnt = 0;
      exp_phys = {24'd0, 1'b1, IDLE_K}; exp_under = 0; prev_grant = 0;
      d_ackd = 0; t_ackd = 0;
      return;
    end
    ed = (owner == O_D) && dreq;
    et = (owner == O_T) && treq;
    chk("phys", int'({phys_k, phys_b}), exp_phys);
    chk("underrun", int'(under), exp_under);
    chk("grant", int'(grant), owner == O_D ? 1 : (owner == O_T ? 2 : 0));
    chk("busy", int'(busy), int'(owner != O_NONE));
    chk("dllp_ack", int'(dack), int'(ed));
    chk("tlp_ack", int'(tack), int'(et));
    if (phys_k && phys_b == SKP_K) skp_seen++;
    if (under) u_cnt++;
    if (grant != 2'b00 && prev_grant == 0) gq.push_back(int'(grant));
    prev_grant = int'(grant);

    d_ackd = ed; t_ackd = et;
    exp_phys = {24'd0, 1'b1, IDLE_K};
    exp_under = 0;
    if (owner == O_NONE) begin
      if (sync_cnt >= 2) begin
        if (SKP_EN && elapsed >= SKP_IVL) begin
          owner = O_SKP; skp_left = 2; elapsed = -1;
        end else if (dreq && !(treq && streak == BURST)) begin
          owner = O_D; streak = treq ? streak + 1 : 0;
        end else if (treq) begin
          owner = O_T; streak = 0;
        end
      end
    end else if (owner == O_D) begin
      if (dreq) begin exp_phys = {22'd0, dk, db}; if (dlast) owner = O_NONE; end
      else exp_under = 1;
    end else if (owner == O_T) begin
      if (treq) begin exp_phys = {22'd0, tk, tb}; if (tlast) owner = O_NONE; end
      else exp_under = 1;
    end else begin
      exp_phys = {24'd0, 1'b1, SKP_K};
      skp_left--;
      if (skp_left == 0) owner = O_NONE;
    end
    if (sync_cnt >= 2 && elapsed < SKP_IVL) elapsed++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic run_until_quiet(int budget);
    int n = 0;
    while (!(dq.size() == 0 && tq.size() == 0 && owner == O_NONE) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain", int'(dq.size() == 0 && tq.size() == 0 && owner == O_NONE), 1);
  endtask

  initial begin
    int n;
    exp31 = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    drive();
    repeat (3) cycle();
    rst_n = 1'b1;

    // Lone 6-byte DLLP, TLP framer idle.
    d_acks = 0; gq.delete();
    push_pkt(0, 6, 1'b1);
    run_until_quiet(100);
    chk("d30_acks", d_acks, 6);
    chk("d30_grant", gq.size() > 0 ? gq[0] : 0, 1);

    // Both framers requesting continuously: burst limit forces a TLP turn.
    gq.delete();
    for (int i = 0; i < 10; i++) push_pkt(0, 2, 1'b0);
    for (int i = 0; i < 4; i++) push_pkt(1, 2, 1'b0);
    run_until_quiet(400);
    for (int i = 0; i < 10; i++)
      chk($sformatf("g31_order[%0d]", i), i < gq.size() ? gq[i] : 0, exp31[i]);

    // 20-byte TLP whose framer drops its request for 3 cycles at byte 8.
    t_acks = 0; u_cnt = 0; arm_t_stall = 1;
    push_pkt(1, 20, 1'b0);
    run_until_quiet(200);
    chk("u32_pulses", u_cnt, 3);
    chk("u32_bytes", t_acks, 20);

    // Randomized traffic with random stalls.
    rnd_mode = 1;
    repeat (1500) cycle();
    rnd_mode = 0;
    run_until_quiet(500);

    // Reset asserted while byte 5 of a TLP is being acked.
    t_acks = 0; n = 0;
    push_pkt(1, 10, 1'b0);
    while (t_acks != 4 && n < 200) begin cycle(); n++; end
    chk("r33_reach", t_acks, 4);
    chk("r33_pre_ack", int'(tack), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r33_phys", int'({phys_k, phys_b}), int'({1'b1, IDLE_K}));
    chk("r33_acks", int'({dack, tack}), 0);
    chk("r33_grant", int'({grant, busy}), 0);
    dq.delete(); tq.delete(); stall_d = 0; stall_t = 0;
    repeat (2) cycle();
    rst_n = 1'b1;
    // A fresh DLLP after release, then a long TLP that is still in flight
    // when the SKP interval expires.
    d_acks = 0; t_acks = 0;
    push_pkt(0, 6, 1'b1);
    push_pkt(1, 20, 1'b0);
    run_until_quiet(300);
    chk("r33_dllp_acks", d_acks, 6);
    chk("r34_tlp_acks", t_acks, 20);
    repeat (20) cycle();
    chk("skp_k_seen", int'(skp_seen > 0), int'(SKP_EN));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
